// File: rtl/cam_fifo_pkg.sv
// Shared word format and helpers for the camera FIFO.
// Bit 16 of every word marks the start of a frame.
package cam_fifo_pkg;

    localparam int CAM_DATA_WIDTH = 17;
    localparam int FRAME_START_BIT = 16;
    localparam logic [CAM_DATA_WIDTH-1:0] FRAME_START_WORD = 17'h10000;

    typedef logic [CAM_DATA_WIDTH-1:0] cam_word_t;

    function automatic logic is_frame_start(cam_word_t w);
        return w[FRAME_START_BIT];
    endfunction

endpackage

// File: rtl/cam_fifo_if.sv
// Write/read handshake bundle of the camera FIFO.
// master drives Data/WrEn/RdEn; slave returns Q and the flags.
interface cam_fifo_if
    import cam_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] Data;
    logic                  WrEn;
    logic                  RdEn;
    logic [DATA_WIDTH-1:0] Q;
    logic                  Empty;
    logic                  Full;

    modport master (
        output Data, WrEn, RdEn,
        input  Q, Empty, Full
    );

    modport slave (
        input  Data, WrEn, RdEn,
        output Q, Empty, Full
    );

endinterface

// File: rtl/cam_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read.
// Read data register clears on reset and holds when not reading.
module cam_fifo_ram
    import cam_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Next read word: fetch on an accepted read, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Storage array write port, no reset on the array itself.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cam_fifo.sv
// Single-clock camera pixel FIFO with registered Empty/Full flags.
// Define CAM_FIFO_WNUM_EN to expose the occupancy count on Wnum.
module cam_fifo
    import cam_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    Data,
    input  logic                     WrEn,
    input  logic                     RdEn,
    output logic [DATA_WIDTH-1:0]    Q,
    output logic                     Empty,
`ifdef CAM_FIFO_WNUM_EN
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Wnum
`else
    output logic                     Full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          wr_acc;
    logic          rd_acc;

    // Accept decisions use the registered flags, so a write while
    // full is dropped even when a read frees a slot this cycle.
    always_comb begin
        wr_acc   = WrEn & ~full_q;
        rd_acc   = RdEn & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_COUNT);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    cam_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (Data),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (Q)
    );

    assign Empty = empty_q;
    assign Full  = full_q;

`ifdef CAM_FIFO_WNUM_EN
    assign Wnum = count_q;
`endif

endmodule

// File: tb/tb_cam_fifo.sv
// Self-checking bench for cam_fifo against a queue-based model.
// Directed phases plus a randomized mixed-traffic phase.
module tb_cam_fifo;
    import cam_fifo_pkg::*;

    localparam int DW    = 17;
    localparam int DEPTH = 1024;

    logic clk;
    logic reset;

    cam_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef CAM_FIFO_WNUM_EN
    logic [$clog2(DEPTH):0] wnum;
`endif

    cam_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Data  (bus.Data),
        .WrEn  (bus.WrEn),
        .RdEn  (bus.RdEn),
        .Q     (bus.Q),
        .Empty (bus.Empty),
`ifdef CAM_FIFO_WNUM_EN
        .Full  (bus.Full),
        .Wnum  (wnum)
`else
        .Full  (bus.Full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mdl [$];
    logic [DW-1:0] mq;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, bit rst, bit wr, bit rd,
                        logic [DW-1:0] d);
        bit wa;
        bit ra;
        @(negedge clk);
        reset    = rst;
        bus.WrEn = wr;
        bus.RdEn = rd;
        bus.Data = d;
        if (rst) begin
            mdl.delete();
            mq = '0;
        end else begin
            wa = wr && (mdl.size() < DEPTH);
            ra = rd && (mdl.size() > 0);
            if (ra) mq = mdl.pop_front();
            if (wa) mdl.push_back(d);
        end
        @(posedge clk);
        #1;
        check({tag, ".Q"}, 32'(bus.Q), 32'(mq));
        check({tag, ".Empty"}, 32'(bus.Empty), 32'(mdl.size() == 0));
        check({tag, ".Full"}, 32'(bus.Full), 32'(mdl.size() == DEPTH));
`ifdef CAM_FIFO_WNUM_EN
        check({tag, ".Wnum"}, 32'(wnum), 32'(mdl.size()));
`endif
    endtask

    function automatic logic [DW-1:0] pix();
        return {1'b0, 16'($urandom)};
    endfunction

    initial begin
        reset    = 1'b0;
        bus.WrEn = 1'b0;
        bus.RdEn = 1'b0;
        bus.Data = '0;
        mq       = '0;

        step("reset", 1, 0, 0, '0);
        step("idle", 0, 0, 0, '0);

        for (int n = 1; n <= 15; n++) begin
            step("frame_wr_sof", 0, 1, 0, FRAME_START_WORD);
            for (int k = 0; k < n; k++) begin
                step("frame_wr", 0, 1, 0, pix());
            end
            for (int k = 0; k <= n; k++) begin
                step("frame_rd", 0, 0, 1, pix());
                check("frame_sof_bit", 32'(bus.Q[FRAME_START_BIT]),
                      32'(k == 0));
            end
        end

        for (int k = 0; k < DEPTH; k++) begin
            step("fill_wr", 0, 1, 0, pix());
        end
        check("full_after_fill", 32'(bus.Full), 32'd1);
        step("overflow_wr", 0, 1, 0, 17'h1FFFF);
        step("overflow_wr_rd", 0, 1, 1, 17'h1AAAA);
        step("refill_wr", 0, 1, 0, pix());
        for (int k = 0; k < DEPTH; k++) begin
            step("drain_rd", 0, 0, 1, pix());
        end
        check("empty_after_drain", 32'(bus.Empty), 32'd1);

        step("uf_wr", 0, 1, 0, 17'h0ABCD);
        step("uf_rd", 0, 0, 1, '0);
        step("uf_empty_rd", 0, 0, 1, '0);
        check("uf_q_hold", 32'(bus.Q), 32'h0ABCD);
        step("uf_empty_rd2", 0, 0, 1, '0);

        step("sim_wr_a", 0, 1, 0, 17'h01111);
        step("sim_wr_rd", 0, 1, 1, 17'h02222);
        check("sim_q_old", 32'(bus.Q), 32'h01111);
        check("sim_not_empty", 32'(bus.Empty), 32'd0);
        step("sim_rd_b", 0, 0, 1, '0);
        check("sim_q_new", 32'(bus.Q), 32'h02222);

        for (int k = 0; k < 5; k++) begin
            step("mid_wr", 0, 1, 0, pix());
        end
        step("mid_rd", 0, 0, 1, '0);
        step("mid_reset", 1, 1, 1, 17'h13333);
        check("mid_reset_q", 32'(bus.Q), 32'd0);
        step("post_reset_rd", 0, 0, 1, '0);
        check("post_reset_q", 32'(bus.Q), 32'd0);

        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), 17'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
